// File: rtl/ga_ctrl_pkg.sv
// Shared types and default widths for the GA main controller and its helpers.
package ga_ctrl_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned M_MAX_DEF   = 8;
  localparam int unsigned B_MAX_W_DEF = 8;
  localparam int unsigned G_MAX_W_DEF = 10;
  localparam int unsigned STALL_W_DEF = 6;
  localparam int unsigned FIT_W_DEF   = 24;
  localparam int unsigned DROP_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL_BUFF = 3'd1,
    ST_GEN_0     = 3'd2,
    ST_GEN_I     = 3'd3,
    ST_W_READY   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MUX_INIT_POP  = 2'd0,
    MUX_MUTATION  = 2'd1,
    MUX_SELECTION = 2'd2
  } mux_sel_t;

endpackage

// File: rtl/ga_stall_tracker.sv
// Tracks best (lowest) fitness of the current run and generations without improvement.
module ga_stall_tracker #(
  parameter int unsigned FIT_W   = 24,
  parameter int unsigned STALL_W = 6
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               load,
  input  logic               update,
  input  logic [FIT_W-1:0]   fit,
  input  logic [STALL_W-1:0] limit,
  output logic               stall_hit
);

  logic [FIT_W-1:0]   best_fit;
  logic [STALL_W-1:0] stall_cnt;
  logic               better;

  assign better = fit < best_fit;

  // Combinational so the controller can finish on the very generation that hits the limit.
  assign stall_hit = update && (limit != '0) && !better &&
                     (STALL_W'(stall_cnt + STALL_W'(1)) == limit);

  always_ff @(posedge clk) begin
    if (clear) begin
      best_fit  <= '0;
      stall_cnt <= '0;
    end else if (load) begin
      best_fit  <= fit;
      stall_cnt <= '0;
    end else if (update) begin
      if (better) begin
        best_fit  <= fit;
        stall_cnt <= '0;
      end else if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

endmodule

// File: rtl/ga_main_ctrl.sv
// Top-level sequencer for the GA engine: buffers inputs, drives generations, publishes weights.
module ga_main_ctrl
  import ga_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned M_MAX   = M_MAX_DEF,
  parameter int unsigned B_MAX_W = B_MAX_W_DEF,
  parameter int unsigned G_MAX_W = G_MAX_W_DEF,
  parameter int unsigned STALL_W = STALL_W_DEF,
  parameter int unsigned FIT_W   = FIT_W_DEF,
  parameter int unsigned DROP_W  = DROP_W_DEF,
  localparam int unsigned CHROM_W = DATA_W * M_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [B_MAX_W-1:0] cnfg_b,
  input  logic [G_MAX_W-1:0] cnfg_g,
  input  logic [STALL_W-1:0] cnfg_stall,
  input  logic               i_ga_enable,
  input  logic               i_valid_pls,
  input  logic               i_abort_pls,
  input  logic               algo_gen_created_pls,
  input  logic [CHROM_W-1:0] algo_gen_best_chrom,
  input  logic [FIT_W-1:0]   algo_gen_best_fit,
  output logic               o_ga_ready,
  output logic               o_valid_lvl,
  output logic [CHROM_W-1:0] o_w_vec_np1,
  output logic [CHROM_W-1:0] o_w_vec_n,
  output logic               o_y_start_pls,
  output logic [31:0]        o_inputs_counter,
  output logic [G_MAX_W-1:0] o_gens_used,
  output logic [DROP_W-1:0]  o_drop_cnt,
  output logic               o_early_stop,
  output logic               o_aborted,
  output logic               self_algo_init_pop_start,
  output logic               self_algo_fit_enable,
  output logic               self_algo_create_new_gen_req_pls,
  output logic               self_algo_stop_create_new_gens_req_pls,
  output logic [1:0]         self_algo_chrom_mux_sel
);

  state_t             state, state_d;
  mux_sel_t           mux_d;
  logic               ready_d, valid_d, y_d, early_d, abort_d;
  logic               init_d, fit_en_d, create_d, stop_d;
  logic [CHROM_W-1:0] np1_d, n_d;
  logic [31:0]        cnt_d, cnt_inc;
  logic [G_MAX_W-1:0] gens_d, gens_inc;
  logic [DROP_W-1:0]  drop_d;
  logic               finish, trk_load, trk_update, stall_hit, clear;

  assign clear    = rst || !i_ga_enable;
  assign cnt_inc  = o_inputs_counter + 32'd1;
  assign gens_inc = o_gens_used + G_MAX_W'(1);

  ga_stall_tracker #(
    .FIT_W   (FIT_W),
    .STALL_W (STALL_W)
  ) u_stall (
    .clk       (clk),
    .clear     (clear),
    .load      (trk_load),
    .update    (trk_update),
    .fit       (algo_gen_best_fit),
    .limit     (cnfg_stall),
    .stall_hit (stall_hit)
  );

  // Next-state and next-output logic; registers hold by default, pulses fall to 0.
  always_comb begin
    state_d    = state;
    mux_d      = mux_sel_t'(self_algo_chrom_mux_sel);
    ready_d    = o_ga_ready;
    valid_d    = o_valid_lvl;
    np1_d      = o_w_vec_np1;
    n_d        = o_w_vec_n;
    cnt_d      = o_inputs_counter;
    gens_d     = o_gens_used;
    drop_d     = o_drop_cnt;
    early_d    = o_early_stop;
    abort_d    = o_aborted;
    fit_en_d   = self_algo_fit_enable;
    init_d     = 1'b0;
    create_d   = 1'b0;
    stop_d     = 1'b0;
    y_d        = 1'b0;
    finish     = 1'b0;
    trk_load   = 1'b0;
    trk_update = 1'b0;

    case (state)
      ST_IDLE: begin
        state_d = ST_FILL_BUFF;
        init_d  = 1'b1;
        mux_d   = MUX_INIT_POP;
        ready_d = 1'b1;
      end
      ST_FILL_BUFF: begin
        if (i_valid_pls) begin
          cnt_d = cnt_inc;
          if (cnt_inc == 32'(cnfg_b)) begin
            state_d  = ST_GEN_0;
            ready_d  = 1'b0;
            fit_en_d = 1'b1;
          end
        end
      end
      ST_GEN_0, ST_GEN_I: begin
        if (i_valid_pls && (o_drop_cnt != '1)) begin
          drop_d = o_drop_cnt + DROP_W'(1);
        end
        if (i_abort_pls) begin
          finish  = 1'b1;
          abort_d = 1'b1;
        end else if (algo_gen_created_pls) begin
          if (state == ST_GEN_0) begin
            state_d  = ST_GEN_I;
            create_d = 1'b1;
            mux_d    = MUX_MUTATION;
            gens_d   = G_MAX_W'(1);
            trk_load = 1'b1;
          end else begin
            trk_update = 1'b1;
            gens_d     = gens_inc;
            if ((gens_inc >= cnfg_g) || stall_hit) begin
              finish  = 1'b1;
              np1_d   = algo_gen_best_chrom;
              early_d = gens_inc < cnfg_g;
            end else begin
              create_d = 1'b1;
            end
          end
        end
      end
      ST_W_READY: begin
        if (i_valid_pls) begin
          state_d  = ST_GEN_0;
          ready_d  = 1'b0;
          valid_d  = 1'b0;
          cnt_d    = cnt_inc;
          fit_en_d = 1'b1;
          n_d      = o_w_vec_np1;
          gens_d   = '0;
          early_d  = 1'b0;
          abort_d  = 1'b0;
          y_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Common wrap-up for both normal completion and abort.
    if (finish) begin
      state_d  = ST_W_READY;
      fit_en_d = 1'b0;
      stop_d   = 1'b1;
      mux_d    = MUX_SELECTION;
      ready_d  = 1'b1;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state                                  <= ST_IDLE;
      o_ga_ready                             <= 1'b0;
      o_valid_lvl                            <= 1'b0;
      o_w_vec_np1                            <= '0;
      o_w_vec_n                              <= '0;
      o_y_start_pls                          <= 1'b0;
      o_inputs_counter                       <= '0;
      o_gens_used                            <= '0;
      o_drop_cnt                             <= '0;
      o_early_stop                           <= 1'b0;
      o_aborted                              <= 1'b0;
      self_algo_init_pop_start               <= 1'b0;
      self_algo_fit_enable                   <= 1'b0;
      self_algo_create_new_gen_req_pls       <= 1'b0;
      self_algo_stop_create_new_gens_req_pls <= 1'b0;
      self_algo_chrom_mux_sel                <= MUX_INIT_POP;
    end else begin
      state                                  <= state_d;
      o_ga_ready                             <= ready_d;
      o_valid_lvl                            <= valid_d;
      o_w_vec_np1                            <= np1_d;
      o_w_vec_n                              <= n_d;
      o_y_start_pls                          <= y_d;
      o_inputs_counter                       <= cnt_d;
      o_gens_used                            <= gens_d;
      o_drop_cnt                             <= drop_d;
      o_early_stop                           <= early_d;
      o_aborted                              <= abort_d;
      self_algo_init_pop_start               <= init_d;
      self_algo_fit_enable                   <= fit_en_d;
      self_algo_create_new_gen_req_pls       <= create_d;
      self_algo_stop_create_new_gens_req_pls <= stop_d;
      self_algo_chrom_mux_sel                <= mux_d;
    end
  end

endmodule

// File: tb/tb_ga_main_ctrl.sv
// Directed bench for ga_main_ctrl: vector table for a full run plus hand-written corner sequences.
module tb_ga_main_ctrl;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [127:0] Z    = 128'd0;
  localparam logic [127:0] CH_A = 128'hAAAA_0001;
  localparam logic [127:0] CH_B = 128'hBBBB_0002;
  localparam logic [127:0] CH_C = 128'hCCCC_0003;
  localparam logic [127:0] CH_D = 128'hDDDD_0004_0000_0000_0000_0000_0000_1234;
  localparam logic [127:0] CH_E = 128'hEEEE_0005;
  localparam logic [127:0] CH_F = 128'hFFFF_0006;
  localparam logic [127:0] CH_G = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  logic         clk = 1'b0;
  logic         rst, en, vin, ab, cr;
  logic [7:0]   cnfg_b;
  logic [9:0]   cnfg_g;
  logic [5:0]   cnfg_stall;
  logic [127:0] chrom;
  logic [23:0]  fit;

  logic         rdy, vl, ys, es, abd, ip, fe, crq, stp;
  logic [127:0] np1, wn;
  logic [31:0]  cnt;
  logic [9:0]   gens;
  logic [15:0]  drop;
  logic [1:0]   mux;

  logic         rdy2, vl2, ys2, es2, abd2, ip2, fe2, crq2, stp2;
  logic [127:0] np1_2, wn2;
  logic [31:0]  cnt2;
  logic [9:0]   gens2;
  logic [1:0]   drop2;
  logic [1:0]   mux2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ga_main_ctrl dut (
    .clk(clk), .rst(rst), .cnfg_b(cnfg_b), .cnfg_g(cnfg_g), .cnfg_stall(cnfg_stall),
    .i_ga_enable(en), .i_valid_pls(vin), .i_abort_pls(ab), .algo_gen_created_pls(cr),
    .algo_gen_best_chrom(chrom), .algo_gen_best_fit(fit),
    .o_ga_ready(rdy), .o_valid_lvl(vl), .o_w_vec_np1(np1), .o_w_vec_n(wn),
    .o_y_start_pls(ys), .o_inputs_counter(cnt), .o_gens_used(gens), .o_drop_cnt(drop),
    .o_early_stop(es), .o_aborted(abd), .self_algo_init_pop_start(ip),
    .self_algo_fit_enable(fe), .self_algo_create_new_gen_req_pls(crq),
    .self_algo_stop_create_new_gens_req_pls(stp), .self_algo_chrom_mux_sel(mux)
  );

  ga_main_ctrl #(.DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnfg_b(cnfg_b), .cnfg_g(cnfg_g), .cnfg_stall(cnfg_stall),
    .i_ga_enable(en), .i_valid_pls(vin), .i_abort_pls(ab), .algo_gen_created_pls(cr),
    .algo_gen_best_chrom(chrom), .algo_gen_best_fit(fit),
    .o_ga_ready(rdy2), .o_valid_lvl(vl2), .o_w_vec_np1(np1_2), .o_w_vec_n(wn2),
    .o_y_start_pls(ys2), .o_inputs_counter(cnt2), .o_gens_used(gens2), .o_drop_cnt(drop2),
    .o_early_stop(es2), .o_aborted(abd2), .self_algo_init_pop_start(ip2),
    .self_algo_fit_enable(fe2), .self_algo_create_new_gen_req_pls(crq2),
    .self_algo_stop_create_new_gens_req_pls(stp2), .self_algo_chrom_mux_sel(mux2)
  );

  typedef struct {
    logic         v, a, c;
    logic [23:0]  fit;
    logic [127:0] chrom;
    logic         rdy, vl, fe, cr, st, ys, ip;
    logic [1:0]   mux;
    logic [9:0]   gens;
    logic [31:0]  cnt;
    logic [127:0] np1, n;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic a, input logic c,
                      input logic [23:0] f, input logic [127:0] ch);
    vin = v; ab = a; cr = c; fit = f; chrom = ch;
    @(posedge clk);
    #1;
    vin = 1'b0; ab = 1'b0; cr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"}, 128'(rdy), 0);
    chk({tag, "_vl"}, 128'(vl), 0);
    chk({tag, "_cnt"}, 128'(cnt), 0);
    chk({tag, "_gens"}, 128'(gens), 0);
    chk({tag, "_drop"}, 128'(drop), 0);
    chk({tag, "_np1"}, np1, 0);
    chk({tag, "_n"}, wn, 0);
    chk({tag, "_mux"}, 128'(mux), 0);
    chk({tag, "_pulses"}, 128'({ys, es, abd, ip, fe, crq, stp}), 0);
    chk({tag, "_dut2"}, 128'(|{rdy2, vl2, ys2, es2, abd2, ip2, fe2, crq2, stp2,
                              np1_2, wn2, cnt2, gens2, drop2, mux2}), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; vin = 1'b0; ab = 1'b0; cr = 1'b0;
    fit = '0; chrom = '0; cnfg_b = 8'd3; cnfg_g = 10'd4; cnfg_stall = 6'd0;

    //            v a c fit      chrom  rdy vl fe cr st ys ip mux    gens    cnt    np1   n
    vecs[0]  = '{N,N,N,24'd0,  Z,    Y,N,N,N,N,N,Y,2'd0,10'd0,32'd0,Z,   Z};
    vecs[1]  = '{Y,N,N,24'd0,  Z,    Y,N,N,N,N,N,N,2'd0,10'd0,32'd1,Z,   Z};
    vecs[2]  = '{Y,N,N,24'd0,  Z,    Y,N,N,N,N,N,N,2'd0,10'd0,32'd2,Z,   Z};
    vecs[3]  = '{Y,N,N,24'd0,  Z,    N,N,Y,N,N,N,N,2'd0,10'd0,32'd3,Z,   Z};
    vecs[4]  = '{N,N,Y,24'd500,CH_A, N,N,Y,Y,N,N,N,2'd1,10'd1,32'd3,Z,   Z};
    vecs[5]  = '{N,N,Y,24'd400,CH_B, N,N,Y,Y,N,N,N,2'd1,10'd2,32'd3,Z,   Z};
    vecs[6]  = '{N,N,Y,24'd450,CH_C, N,N,Y,Y,N,N,N,2'd1,10'd3,32'd3,Z,   Z};
    vecs[7]  = '{N,N,Y,24'd300,CH_D, Y,Y,N,N,Y,N,N,2'd2,10'd4,32'd3,CH_D,Z};
    vecs[8]  = '{N,N,N,24'd0,  Z,    Y,Y,N,N,N,N,N,2'd2,10'd4,32'd3,CH_D,Z};
    vecs[9]  = '{N,Y,Y,24'd5,  CH_E, Y,Y,N,N,N,N,N,2'd2,10'd4,32'd3,CH_D,Z};
    vecs[10] = '{Y,N,N,24'd0,  Z,    N,N,Y,N,N,Y,N,2'd2,10'd0,32'd4,CH_D,CH_D};
    vecs[11] = '{N,N,Y,24'd100,CH_E, N,N,Y,Y,N,N,N,2'd1,10'd1,32'd4,CH_D,CH_D};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].v, vecs[i].a, vecs[i].c, vecs[i].fit, vecs[i].chrom);
      chk($sformatf("v%0d_rdy", i), 128'(rdy), 128'(vecs[i].rdy));
      chk($sformatf("v%0d_vl", i), 128'(vl), 128'(vecs[i].vl));
      chk($sformatf("v%0d_fe", i), 128'(fe), 128'(vecs[i].fe));
      chk($sformatf("v%0d_cr", i), 128'(crq), 128'(vecs[i].cr));
      chk($sformatf("v%0d_st", i), 128'(stp), 128'(vecs[i].st));
      chk($sformatf("v%0d_ys", i), 128'(ys), 128'(vecs[i].ys));
      chk($sformatf("v%0d_ip", i), 128'(ip), 128'(vecs[i].ip));
      chk($sformatf("v%0d_mux", i), 128'(mux), 128'(vecs[i].mux));
      chk($sformatf("v%0d_gens", i), 128'(gens), 128'(vecs[i].gens));
      chk($sformatf("v%0d_cnt", i), 128'(cnt), 128'(vecs[i].cnt));
      chk($sformatf("v%0d_np1", i), np1, vecs[i].np1);
      chk($sformatf("v%0d_n", i), wn, vecs[i].n);
      chk($sformatf("v%0d_abd", i), 128'(abd), 0);
    end

    // Inputs arriving while generations run are dropped and counted.
    repeat (3) step(Y, N, N, 24'd0, Z);
    chk("drop3_cnt", 128'(drop), 3);
    chk("drop3_inputs", 128'(cnt), 4);
    repeat (2) step(Y, N, N, 24'd0, Z);
    chk("drop5_cnt", 128'(drop), 5);
    chk("drop5_sat", 128'(drop2), 3);
    chk("drop5_state", 128'({crq, stp, gens}), 128'({N, N, 10'd1}));

    // Abort beats a simultaneous generation.
    step(N, Y, Y, 24'd1, CH_F);
    chk("abort_flag", 128'(abd), 1);
    chk("abort_np1", np1, CH_D);
    chk("abort_stop", 128'(stp), 1);
    chk("abort_lvls", 128'({rdy, vl, fe, mux, gens, es}), 128'({Y, Y, N, 2'd2, 10'd1, N}));
    step(N, N, N, 24'd0, Z);
    chk("abort_stop_once", 128'(stp), 0);
    chk("abort_hold", 128'(abd), 1);

    // Early stop on fitness stall.
    cnfg_g = 10'd10; cnfg_stall = 6'd2;
    step(Y, N, N, 24'd0, Z);
    chk("rerun_start", 128'({ys, abd, cnt, gens}), 128'({Y, N, 32'd5, 10'd0}));
    chk("rerun_n", wn, CH_D);
    step(N, N, Y, 24'd100, CH_A);
    step(N, N, Y, 24'd90, CH_B);
    step(N, N, Y, 24'd90, CH_C);
    chk("stall_g3", 128'({crq, stp, gens}), 128'({Y, N, 10'd3}));
    step(N, N, Y, 24'd90, CH_G);
    chk("stall_stop", 128'({stp, crq, vl, es}), 128'({Y, N, Y, Y}));
    chk("stall_gens", 128'(gens), 4);
    chk("stall_np1", np1, CH_G);

    // Reset in the middle of a run.
    step(Y, N, N, 24'd0, Z);
    step(N, N, Y, 24'd100, CH_A);
    chk("pre_rst_gen_i", 128'({gens, crq}), 128'({10'd1, Y}));
    rst = 1'b1;
    step(N, N, Y, 24'd50, CH_B);
    check_zero("rst_mid");
    rst = 1'b0;
    step(N, N, N, 24'd0, Z);
    chk("post_rst_idle", 128'({rdy, ip}), 128'({Y, Y}));

    // Enable drop in the middle of a run.
    repeat (3) step(Y, N, N, 24'd0, Z);
    step(N, N, Y, 24'd70, CH_C);
    chk("pre_en_gen_i", 128'({gens, cnt}), 128'({10'd1, 32'd3}));
    en = 1'b0;
    step(N, N, Y, 24'd60, CH_D);
    check_zero("en_low");
    step(Y, N, N, 24'd0, Z);
    check_zero("en_low_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ga_main_ctrl.md
GA_MAIN_CTRL -- requirements
Module: ga_main_ctrl

Interface
REQ-001 Param DATA_W, default 16, width of one weight element.
REQ-002 Param M_MAX, default 8, weights per chromosome (>=1); CHROM_W = DATA_W*M_MAX.
REQ-003 Params B_MAX_W 8, G_MAX_W 10, STALL_W 6, FIT_W 24, DROP_W 16: widths of buffer-fill count, generation count, stall limit, fitness, drop counter.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cnfg_b  in  B_MAX_W  inputs to buffer before first run (>=1); cnfg_g  in  G_MAX_W  max generations per input (>=2); cnfg_stall  in  STALL_W  early-stop limit, 0 = disabled.
REQ-007 i_ga_enable  in  1  level; low forces IDLE and clears all registers next edge.
REQ-008 i_valid_pls  in  1  new input sample; i_abort_pls  in  1  abort current run.
REQ-009 algo_gen_created_pls  in  1; algo_gen_best_chrom  in  CHROM_W; algo_gen_best_fit  in  FIT_W unsigned, lower is better.
REQ-010 o_ga_ready  out  1; o_valid_lvl  out  1; o_w_vec_np1  out  CHROM_W  best chromosome of last completed run; o_w_vec_n  out  CHROM_W  chromosome in use for current input.
REQ-011 o_y_start_pls  out  1  start external inner product on o_w_vec_n; o_inputs_counter  out  32; o_gens_used  out  G_MAX_W; o_drop_cnt  out  DROP_W; o_early_stop  out  1; o_aborted  out  1.
REQ-012 self_algo_init_pop_start, self_algo_fit_enable, self_algo_create_new_gen_req_pls, self_algo_stop_create_new_gens_req_pls  out  1 each; self_algo_chrom_mux_sel  out  2 (0 INIT_POP, 1 MUTATION, 2 SELECTION).

Function
REQ-013 All outputs SHALL be registered; every pulse output asserts exactly one cycle, one cycle after its triggering input edge.
REQ-014 States: IDLE, FILL_BUFF, GEN_0, GEN_I, W_READY.
REQ-015 IDLE, enable high: -> FILL_BUFF; init_pop_start pulse, mux_sel=0, ga_ready=1.
REQ-016 FILL_BUFF: each i_valid_pls increments inputs_counter; when the incremented value equals cnfg_b: -> GEN_0, ga_ready=0, fit_enable=1.
REQ-017 GEN_0, gen_created: -> GEN_I, create_req pulse, mux_sel=1, gens_used=1, best_fit register loaded, stall count=0.
REQ-018 GEN_I, gen_created: gens_used+1; if algo_gen_best_fit < stored best_fit, store it and clear stall count, else stall count+1.
REQ-019 GEN_I finish when gens_used==cnfg_g, or cnfg_stall!=0 and stall count==cnfg_stall (o_early_stop=1 only if gens_used<cnfg_g): fit_enable=0, stop pulse, mux_sel=2, ga_ready=1, valid_lvl=1, w_vec_np1=algo_gen_best_chrom, -> W_READY; else create_req pulse.
REQ-020 i_abort_pls in GEN_0/GEN_I: same as finish except w_vec_np1 unchanged, o_aborted=1; abort wins over simultaneous gen_created.
REQ-021 W_READY, i_valid_pls: -> GEN_0; ga_ready=0, valid_lvl=0, inputs_counter+1, fit_enable=1, w_vec_n=w_vec_np1, gens_used=0, early_stop=0, aborted=0, y_start pulse.
REQ-022 i_valid_pls in GEN_0/GEN_I SHALL be dropped and increment o_drop_cnt, saturating at all-ones.
REQ-023 inputs_counter wraps modulo 2^32; gens_used never exceeds cnfg_g.
REQ-024 i_abort_pls outside GEN_0/GEN_I, and gen_created outside GEN_0/GEN_I, SHALL be ignored.

Reset
REQ-025 rst or enable low: state IDLE, all counters, chromosomes, flags and pulses 0, mux_sel=0, ga_ready=0; rst overrides all inputs, mid-run included.

Structure
REQ-026 State enum, mux-sel enum and default widths SHALL live in shared package ga_ctrl_pkg.
REQ-027 Stall/best-fitness tracking SHALL be sub-module ga_stall_tracker (load, update, clear; outputs stall_hit).

Verification
REQ-028 cnfg_b=3, cnfg_g=4, stall=0: 3 valids -> GEN_0; 4 gen_created -> valid_lvl=1, gens_used=4, w_vec_np1=4th chrom.
REQ-029 stall=2, fits 100,90,90,90: finish after 4th gen, early_stop=1, gens_used=4 with cnfg_g=10.
REQ-030 abort in same cycle as gen_created during GEN_I: aborted=1, w_vec_np1 unchanged, stop pulse once.
REQ-031 3 valids during GEN_I: drop_cnt=3, inputs_counter unchanged; DROP_W=2, 5 drops -> drop_cnt=3.
REQ-032 rst asserted mid-GEN_I: next cycle IDLE, all outputs 0; enable low likewise.
